// File: rtl/mux16_rr_sched_pkg.sv
// rtl/mux16_rr_sched_pkg.sv - shared constants, state codes and helpers for the 16:1 mux scheduler
package mux16_rr_sched_pkg;

    localparam int NCH  = 16;
    localparam int SELW = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARB    = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    function automatic logic [NCH-1:0] sel_to_onehot(input logic [SELW-1:0] s);
        return NCH'(1) << s;
    endfunction

endpackage

// File: rtl/mux16_rr_sched_rr_pick16.sv
// rtl/mux16_rr_sched_rr_pick16.sv - combinational rotating-priority picker, first request above i_last wins
module rr_pick16
    import mux16_rr_sched_pkg::*;
(
    input  logic [NCH-1:0]  i_req,
    input  logic [SELW-1:0] i_last,
    output logic [SELW-1:0] o_idx,
    output logic            o_any
);

    logic [SELW-1:0] w_cand;

    // Scan from the lowest priority (last itself) up to last+1 so the
    // highest-priority hit is the final assignment.
    always_comb begin
        o_idx  = i_last;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = NCH; k >= 1; k--) begin
            w_cand = i_last + SELW'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// rtl/mux16_rr_sched.sv - round-robin select scheduler driving the 16:1 mux tree with settle delay and valid/ready
module mux16_rr_sched
    import mux16_rr_sched_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [NCH-1:0]  i_req,
    input  logic            i_out_ready,
    output logic [SELW-1:0] o_sel,
    output logic [NCH-1:0]  o_grant,
    output logic            o_sel_valid,
    output logic            o_busy
);

    localparam bit         HAS_SETTLE = (SETTLE != 0);
    localparam logic [3:0] CNT_LOAD   = HAS_SETTLE ? 4'(SETTLE - 1) : 4'd0;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [SELW-1:0] r_last;
    logic [3:0]      r_cnt;
    logic [SELW-1:0] w_idx;
    logic            w_any;
    logic            w_start;
    logic            w_xfer;

    rr_pick16 u_pick (
        .i_req  (i_req),
        .i_last (r_last),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_start = i_en && (|i_req);
    assign w_xfer  = (r_state == ST_HOLD) && i_out_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_ARB;
            ST_ARB: begin
                if (!w_any)          w_next = ST_IDLE;
                else if (HAS_SETTLE) w_next = ST_SETTLE;
                else                 w_next = ST_HOLD;
            end
            ST_SETTLE: if (r_cnt == 4'd0) w_next = ST_HOLD;
            ST_HOLD:   if (i_out_ready) w_next = w_start ? ST_ARB : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 4'hF;
            r_cnt       <= 4'd0;
            o_sel       <= '0;
            o_grant     <= '0;
            o_sel_valid <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            o_busy      <= (w_next != ST_IDLE);
            o_sel_valid <= (w_next == ST_HOLD);
            if (r_state == ST_ARB && w_any) begin
                o_sel   <= w_idx;
                o_grant <= sel_to_onehot(w_idx);
                r_cnt   <= CNT_LOAD;
            end else if (r_state == ST_SETTLE && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_xfer) r_last <= o_sel;
            if (w_next == ST_IDLE) o_grant <= '0;
        end
    end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb/tb_mux16_rr_sched.sv - directed scoreboard bench for mux16_rr_sched (SETTLE=2 and SETTLE=0 builds)
module tb_mux16_rr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] req = 16'h0;
    logic        out_ready = 1'b0;

    logic [3:0]  sel, sel0;
    logic [15:0] grant, grant0;
    logic        sel_valid, sel_valid0;
    logic        busy, busy0;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    mux16_rr_sched #(.SETTLE(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_out_ready(out_ready),
        .o_sel(sel), .o_grant(grant), .o_sel_valid(sel_valid), .o_busy(busy)
    );

    mux16_rr_sched #(.SETTLE(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_req(req), .i_out_ready(out_ready),
        .o_sel(sel0), .o_grant(grant0), .o_sel_valid(sel_valid0), .o_busy(busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Pops one expected channel per handshake; loads next_req at the final one.
    task automatic drain(input logic [15:0] next_req, input int budget);
        logic [3:0]  e;
        logic [15:0] oh;
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            if (sel_valid && out_ready) begin
                e  = exp_q.pop_front();
                oh = 16'h1 << e;
                chk("hs_sel", 32'(sel), 32'(e));
                chk("hs_grant", 32'(grant), 32'(oh));
                if (exp_q.size() == 0) req = next_req;
            end
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [3:0] held_sel;
        int n;

        // reset state
        do_reset();
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(sel_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // single request latency: cycle 0 stimulus
        en = 1'b1;
        req = 16'h0001;
        tick();
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_grant", 32'(grant), 32'd0);
        chk("c1_valid0", 32'(sel_valid0), 32'd0);
        tick();
        chk("c2_sel", 32'(sel), 32'd0);
        chk("c2_grant", 32'(grant), 32'h0001);
        chk("c2_valid", 32'(sel_valid), 32'd0);
        chk("c2_valid0", 32'(sel_valid0), 32'd1);
        chk("c2_grant0", 32'(grant0), 32'h0001);
        tick();
        chk("c3_valid", 32'(sel_valid), 32'd0);
        tick();
        chk("c4_valid", 32'(sel_valid), 32'd1);
        chk("c4_grant", 32'(grant), 32'h0001);
        out_ready = 1'b1;
        req = 16'h0;
        tick();
        chk("c5_valid", 32'(sel_valid), 32'd0);
        chk("c5_busy", 32'(busy), 32'd0);
        chk("c5_grant", 32'(grant), 32'd0);

        // full round robin from reset pointer, then wrap with 8001
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        req = 16'hFFFF;
        for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
        exp_q.push_back(4'd0);
        drain(16'h8001, 200);
        exp_q.push_back(4'd15);
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd15);
        drain(16'h0000, 60);
        tick();
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // drop req/en during HOLD while stalled
        out_ready = 1'b0;
        req = 16'h0010;
        exp_q.push_back(4'd4);
        n = 0;
        while (!sel_valid && n < 20) begin
            tick();
            n++;
        end
        chk("hold_reach", 32'(sel_valid), 32'd1);
        held_sel = sel;
        req = 16'h0;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(sel_valid), 32'd1);
            chk("hold_sel", 32'(sel), 32'(held_sel));
        end
        out_ready = 1'b1;
        drain(16'h0000, 4);
        chk("hold_end_valid", 32'(sel_valid), 32'd0);
        chk("hold_end_busy", 32'(busy), 32'd0);

        // async reset in SETTLE
        en = 1'b1;
        out_ready = 1'b0;
        req = 16'h0100;
        tick();
        tick();
        chk("pre_rst_sel", 32'(sel), 32'd8);
        rst = 1'b1;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_valid", 32'(sel_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        req = 16'h0003;
        out_ready = 1'b1;
        exp_q.push_back(4'd0);
        drain(16'h0000, 20);
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
